// File: rtl/rc4_stream_ctrl.sv
// rc4_stream_ctrl: buffers one frame, sequences S-box init and the rc4_crypt core, and queues its results.
// Optional RC4_PROTO_CHK_EN adds a sticky proto_err output for stray core strobes / S-box ready drops.
module rc4_stream_ctrl #(
  parameter int unsigned FRAME_AW = 8,
  parameter logic [7:0]  PAD_BYTE = 8'h00
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [127:0] key_in,
  input  logic         s_valid,
  input  logic [7:0]   s_data,
  input  logic         s_last,
  output logic         s_ready,
  output logic         m_valid,
  output logic [7:0]   m_data,
  output logic         m_last,
  input  logic         m_ready,
  output logic         busy,
  output logic         sbox_init,
  input  logic         sbox_ready,
  output logic         rc4_ini,
  output logic [127:0] rc4_key,
  output logic [7:0]   rc4_data_in,
  input  logic [7:0]   rc4_data_out,
  input  logic         rc4_data_wr
`ifdef RC4_PROTO_CHK_EN
  ,
  output logic         proto_err
`endif
);

  localparam int unsigned FRAME_LEN = 1 << FRAME_AW;
  localparam int unsigned CW        = FRAME_AW + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_SINIT,
    ST_SWAIT,
    ST_KICK,
    ST_RUN
  } state_t;

  state_t                r_state;
  logic [7:0]            r_in_buf  [FRAME_LEN];
  logic [8:0]            r_out_buf [FRAME_LEN];
  logic [FRAME_AW-1:0]   r_wr_ptr;
  logic [FRAME_AW-1:0]   r_rd_ptr;
  logic [CW-1:0]         r_len;
  logic [FRAME_AW-1:0]   r_oh_ptr;
  logic [FRAME_AW-1:0]   r_ot_ptr;
  logic [CW-1:0]         r_ocnt;
  logic                  r_s_ready;
  logic                  r_busy;
  logic                  r_sbox_init;
  logic                  r_rc4_ini;
  logic [127:0]          r_rc4_key;

  logic                  w_s_fire;
  logic                  w_close;
  logic                  w_in_run;
  logic                  w_strobe;
  logic                  w_real;
  logic                  w_real_last;
  logic                  w_push;
  logic                  w_pop;
  logic [8:0]            w_head;

  assign w_s_fire    = s_valid & r_s_ready;
  // wr_ptr is all-ones only on the final buffer slot, never in IDLE
  assign w_close     = w_s_fire & (s_last | (&r_wr_ptr));
  assign w_in_run    = (r_state == ST_RUN);
  assign w_strobe    = rc4_data_wr & w_in_run;
  assign w_real      = CW'(r_rd_ptr) < r_len;
  assign w_real_last = CW'(r_rd_ptr) == (r_len - CW'(1));
  assign w_push      = w_strobe & w_real;
  assign w_pop       = m_valid & m_ready;
  assign w_head      = r_out_buf[r_oh_ptr];

  assign s_ready     = r_s_ready;
  assign busy        = r_busy;
  assign sbox_init   = r_sbox_init;
  assign rc4_ini     = r_rc4_ini;
  assign rc4_key     = r_rc4_key;
  assign m_valid     = (r_ocnt != '0);
  assign m_data      = m_valid ? w_head[7:0] : 8'h00;
  assign m_last      = m_valid & w_head[8];
  assign rc4_data_in = (w_in_run && w_real) ? r_in_buf[r_rd_ptr] : PAD_BYTE;

  // Frame and result storage; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_s_fire) r_in_buf[r_wr_ptr] <= s_data;
    if (w_push)   r_out_buf[r_ot_ptr] <= {w_real_last, rc4_data_out};
  end

  // Frame sequencer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_s_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_sbox_init <= 1'b0;
      r_rc4_ini   <= 1'b0;
      r_rc4_key   <= '0;
    end else begin
      r_sbox_init <= 1'b0;
      r_rc4_ini   <= 1'b0;
      case (r_state)
        ST_IDLE, ST_FILL: begin
          r_s_ready <= 1'b1;
          r_busy    <= 1'b0;
          if (w_s_fire) begin
            if (r_state == ST_IDLE) r_rc4_key <= key_in;
            if (w_close) begin
              r_len     <= CW'(r_wr_ptr) + CW'(1);
              r_wr_ptr  <= '0;
              r_s_ready <= 1'b0;
              r_busy    <= 1'b1;
              r_state   <= ST_SINIT;
            end else begin
              r_wr_ptr  <= r_wr_ptr + FRAME_AW'(1);
              r_state   <= ST_FILL;
            end
          end
        end
        ST_SINIT: begin
          // Output buffer must be empty so the whole frame fits
          if (r_ocnt == '0) begin
            r_sbox_init <= 1'b1;
            r_state     <= ST_SWAIT;
          end
        end
        ST_SWAIT: begin
          // Skip the request cycle: ready may still reflect the previous load
          if (sbox_ready && !r_sbox_init) begin
            r_rc4_ini <= 1'b1;
            r_state   <= ST_KICK;
          end
        end
        ST_KICK: begin
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_strobe) begin
            r_rd_ptr <= r_rd_ptr + FRAME_AW'(1);
            if (&r_rd_ptr) begin
              r_wr_ptr  <= '0;
              r_s_ready <= 1'b1;
              r_busy    <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output FIFO pointers; simultaneous push and pop leave the count unchanged
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_oh_ptr <= '0;
      r_ot_ptr <= '0;
      r_ocnt   <= '0;
    end else begin
      if (w_push) r_ot_ptr <= r_ot_ptr + FRAME_AW'(1);
      if (w_pop)  r_oh_ptr <= r_oh_ptr + FRAME_AW'(1);
      if (w_push && !w_pop)      r_ocnt <= r_ocnt + CW'(1);
      else if (!w_push && w_pop) r_ocnt <= r_ocnt - CW'(1);
    end
  end

`ifdef RC4_PROTO_CHK_EN
  logic r_proto_err;
  logic r_sbox_ready_q;

  // Sticky flag: strobe outside RUN, or S-box losing its table while the core uses it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_proto_err    <= 1'b0;
      r_sbox_ready_q <= 1'b0;
    end else begin
      r_sbox_ready_q <= sbox_ready;
      if ((rc4_data_wr && !w_in_run) ||
          (((r_state == ST_KICK) || w_in_run) && r_sbox_ready_q && !sbox_ready))
        r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`endif

endmodule
